// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: 8259-style priority resolver, in-service register and INTA acknowledge sequencer.
module interrupt_sequencer #(
  parameter int VECTOR_BASE_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               interrupt_req_register,
  input  logic [7:0]               interrupt_mask,
  input  logic [VECTOR_BASE_W-1:0] vector_base,
  input  logic                     auto_eoi,
  input  logic                     rotate_on_eoi,
  input  logic                     inta_n,
  input  logic                     eoi_cmd,
  input  logic                     eoi_specific,
  input  logic [2:0]               eoi_level,
  output logic                     int_out,
  output logic [7:0]               clear_interrupt_req,
  output logic [7:0]               in_service_register,
  output logic [VECTOR_BASE_W+2:0] vector_out,
  output logic                     vector_valid
);
  typedef enum logic [1:0] {IDLE, PENDING, ACK1, ACK2} state_t;
  state_t      state;
  logic [2:0]  lowest, sel, isr_top, win, lvl, eoi_lvl;
  logic [3:0]  isr_rank;
  logic [7:0]  req, set_mask, clr_mask;
  logic        inta_q, spurious, win_any, inta_fall, inta_rise, eoi_hit, auto_hit;
  assign req       = interrupt_req_register & ~interrupt_mask;
  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;
  // Rank i is the level lowest+1+i; scanning ranks downward leaves the highest-priority hit.
  always_comb begin
    isr_rank = 4'd8;
    isr_top = 3'd0;
    win_any = 1'b0;
    win = 3'd0;
    lvl = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      lvl = lowest + 3'(i) + 3'd1;
      if (in_service_register[lvl]) begin
        isr_rank = 4'(i);
        isr_top = lvl;
      end
    end
    for (int i = 7; i >= 0; i--) begin
      lvl = lowest + 3'(i) + 3'd1;
      if (req[lvl] && 4'(i) < isr_rank) begin
        win_any = 1'b1;
        win = lvl;
      end
    end
  end
  assign eoi_hit  = eoi_cmd & (eoi_specific | (|in_service_register));
  assign eoi_lvl  = eoi_specific ? eoi_level : isr_top;
  assign auto_hit = (state == ACK2) & vector_valid & inta_rise & auto_eoi & ~spurious;
  assign set_mask = (8'd1 << win) & {8{(state == PENDING) & inta_fall & win_any}};
  assign clr_mask = ((8'd1 << eoi_lvl) & {8{eoi_hit}}) | ((8'd1 << sel) & {8{auto_hit}});
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      lowest <= 3'd7;
      sel <= 3'd0;
      spurious <= 1'b0;
      inta_q <= 1'b1;
      int_out <= 1'b0;
      clear_interrupt_req <= 8'd0;
      in_service_register <= 8'd0;
      vector_out <= '0;
      vector_valid <= 1'b0;
    end else begin
      inta_q <= inta_n;
      // Set is OR-ed after the clear so a same-bit EOI loses to a new acknowledge.
      in_service_register <= (in_service_register & ~clr_mask) | set_mask;
      clear_interrupt_req <= set_mask;
      if (rotate_on_eoi && (auto_hit || eoi_hit)) lowest <= auto_hit ? sel : eoi_lvl;
      case (state)
        IDLE: if (win_any) begin
          state <= PENDING;
          int_out <= 1'b1;
        end
        PENDING: if (inta_fall) begin
          state <= ACK1;
          int_out <= 1'b0;
          sel <= win_any ? win : 3'd7;
          spurious <= ~win_any;
        end
        ACK1: if (inta_rise) state <= ACK2;
        ACK2: if (inta_fall) begin
          vector_valid <= 1'b1;
          vector_out <= {vector_base, sel};
        end else if (inta_rise && vector_valid) begin
          vector_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_interrupt_sequencer;
  logic       clk = 1'b0, reset = 1'b1;
  logic [7:0] irr = 8'd0, imr = 8'd0;
  logic [4:0] base = 5'd0;
  logic       auto_eoi = 1'b0, rot = 1'b0, inta_n = 1'b1, eoi_cmd = 1'b0, eoi_spec = 1'b0;
  logic [2:0] eoi_lvl = 3'd0;
  logic       int_out, vector_valid;
  logic [7:0] clear_interrupt_req, in_service_register, vector_out;
  int         n_vec = 0, n_err = 0;
  logic [7:0] c, v;

  always #5 clk = ~clk;

  interrupt_sequencer #(.VECTOR_BASE_W(5)) dut (
    .clk(clk), .reset(reset),
    .interrupt_req_register(irr), .interrupt_mask(imr), .vector_base(base),
    .auto_eoi(auto_eoi), .rotate_on_eoi(rot), .inta_n(inta_n),
    .eoi_cmd(eoi_cmd), .eoi_specific(eoi_spec), .eoi_level(eoi_lvl),
    .int_out(int_out), .clear_interrupt_req(clear_interrupt_req),
    .in_service_register(in_service_register), .vector_out(vector_out),
    .vector_valid(vector_valid)
  );

  // Behavioural model: priority by rank distance from the lowest pointer, handshake as a step counter.
  logic       m_int, m_vv, m_prev, m_spur;
  logic [7:0] m_clr, m_isr, m_vec, m_req, m_nisr;
  logic [2:0] m_sel;
  int         m_low, m_step, m_nlow, top_rank, top_lvl, win, win_rank, e;
  bit         fall, rise;

  function automatic int rank(input int l, input int low);
    return (l - low + 15) % 8;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_int = 0; m_vv = 0; m_prev = 1; m_spur = 0;
      m_clr = 0; m_isr = 0; m_vec = 0; m_sel = 0;
      m_low = 7; m_step = 0;
    end else begin
      m_req = irr & ~imr;
      top_rank = 8; top_lvl = -1;
      for (int l = 0; l < 8; l++)
        if (m_isr[l] && rank(l, m_low) < top_rank) begin
          top_rank = rank(l, m_low);
          top_lvl = l;
        end
      win = -1; win_rank = 8;
      for (int l = 0; l < 8; l++)
        if (m_req[l] && rank(l, m_low) < top_rank && rank(l, m_low) < win_rank) begin
          win_rank = rank(l, m_low);
          win = l;
        end
      fall = m_prev && !inta_n;
      rise = !m_prev && inta_n;
      m_prev = inta_n;
      m_nisr = m_isr; m_nlow = m_low; m_clr = 0;
      if (eoi_cmd) begin
        e = eoi_spec ? int'(eoi_lvl) : top_lvl;
        if (e >= 0) begin
          m_nisr[e] = 0;
          if (rot) m_nlow = e;
        end
      end
      case (m_step)
        0: if (win >= 0) begin m_step = 1; m_int = 1; end
        1: if (fall) begin
          m_step = 2; m_int = 0;
          if (win >= 0) begin
            m_sel = 3'(win); m_spur = 0; m_nisr[win] = 1; m_clr[win] = 1;
          end else begin
            m_sel = 3'd7; m_spur = 1;
          end
        end
        2: if (rise) m_step = 3;
        default: if (fall) begin
          m_vv = 1; m_vec = {base, m_sel};
        end else if (rise && m_vv) begin
          m_vv = 0; m_step = 0;
          if (auto_eoi && !m_spur) begin
            m_nisr[m_sel] = 0;
            if (rot) m_nlow = m_sel;
          end
        end
      endcase
      m_isr = m_nisr; m_low = m_nlow;
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("int_out", {7'd0, int_out}, {7'd0, m_int});
    check("clear", clear_interrupt_req, m_clr);
    check("isr", in_service_register, m_isr);
    check("vvalid", {7'd0, vector_valid}, {7'd0, m_vv});
    check("vector", vector_out, m_vec);
  endtask

  task automatic ack(output logic [7:0] clr_seen, output logic [7:0] vec_seen);
    inta_n = 0; tick();
    clr_seen = clear_interrupt_req;
    irr = irr & ~clr_seen;
    inta_n = 1; tick();
    inta_n = 0; tick();
    vec_seen = vector_out;
    inta_n = 1; tick();
  endtask

  initial begin
    tick();
    check("rst_isr", in_service_register, 8'h00);
    check("rst_int", {7'd0, int_out}, 8'h00);
    reset = 0;
    irr = 8'h24; base = 5'h08; tick();
    check("s1_int", {7'd0, int_out}, 8'h01);
    ack(c, v);
    check("s1_clr", c, 8'h04);
    check("s1_vec", v, 8'h42);
    check("s1_isr", in_service_register, 8'h04);
    irr = 8'h88; tick(); tick();
    check("nest_block", {7'd0, int_out}, 8'h00);
    irr = 8'h02; tick();
    check("nest_int", {7'd0, int_out}, 8'h01);
    ack(c, v);
    check("nest_vec", v, 8'h41);
    eoi_cmd = 1; tick(); tick(); eoi_cmd = 0;
    check("eoi_clear", in_service_register, 8'h00);
    irr = 8'h10; tick();
    irr = 8'h00;
    ack(c, v);
    check("spur_clr", c, 8'h00);
    check("spur_vec", v, 8'h47);
    check("spur_isr", in_service_register, 8'h00);
    rot = 1; irr = 8'h08; tick();
    ack(c, v);
    check("rot_vec", v, 8'h43);
    eoi_cmd = 1; tick(); eoi_cmd = 0;
    check("rot_eoi", in_service_register, 8'h00);
    irr = 8'h11; tick();
    ack(c, v);
    check("rot_order", c, 8'h10);
    irr = 8'h00; eoi_cmd = 1; tick(); eoi_cmd = 0; rot = 0;
    auto_eoi = 1; irr = 8'h40; tick();
    ack(c, v);
    check("aeoi_vec", v, 8'h46);
    check("aeoi_isr", in_service_register, 8'h00);
    auto_eoi = 0;
    irr = 8'h01; tick();
    inta_n = 0; tick();
    irr = 8'h00;
    inta_n = 1; tick();
    inta_n = 0; tick();
    check("pre_rst_vv", {7'd0, vector_valid}, 8'h01);
    reset = 1; #1;
    check("arst_vv", {7'd0, vector_valid}, 8'h00);
    check("arst_isr", in_service_register, 8'h00);
    check("arst_vec", vector_out, 8'h00);
    tick();
    reset = 0;
    inta_n = 1; tick();
    inta_n = 0; tick();
    inta_n = 1; tick();
    check("post_rst_vv", {7'd0, vector_valid}, 8'h00);
    repeat (3000) begin
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 7) == 0) irr = 8'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) imr = ($urandom_range(0, 2) == 0) ? 8'($urandom & $urandom) : 8'h00;
      if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
      eoi_cmd = ($urandom_range(0, 11) == 0);
      eoi_spec = 1'($urandom);
      eoi_lvl = 3'($urandom);
      if ($urandom_range(0, 49) == 0) auto_eoi = ~auto_eoi;
      if ($urandom_range(0, 49) == 0) rot = ~rot;
      if ($urandom_range(0, 99) == 0) base = 5'($urandom);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
